alarm_siren_ctrl: RTL and testbench
===================================

ALARM_SIREN_CTRL -- requirements
Module: alarm_siren_ctrl

Interface
REQ-001 Parameter ENTRY_DELAY, default 8: cycles spent in ENTRY before the siren sounds; legal range 1..2**CNT_W.
REQ-002 Parameter SIREN_TIME, default 16: cycles the siren sounds per trip; legal range 1..2**CNT_W.
REQ-003 Parameter CNT_W, default 8: width of the down-counter and the Count port.
REQ-004 Clk  input  1  system clock; all state changes on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 A  input  1  alarm condition from the upstream combinational alarm block; level, synchronous to Clk.
REQ-007 Arm  input  1  level; request to arm.
REQ-008 Disarm  input  1  level; request to disarm.
REQ-009 Siren  output  1  high while State is SIREN.
REQ-010 Armed  output  1  high in ARMED, ENTRY and SIREN.
REQ-011 Pending  output  1  high while State is ENTRY.
REQ-012 Tripped  output  1  latched flag meaning a trip occurred since the last disarm.
REQ-013 State  output  2  current state encoding.
REQ-014 Count  output  CNT_W  remaining cycles in the current timed state; 0 in other states.

Function
REQ-015 State encoding SHALL be: DISARMED=00, ARMED=01, ENTRY=10, SIREN=11, held in a single registered state machine.
REQ-016 Siren, Armed, Pending and State SHALL be Moore outputs decoded from the state register only, with no combinational path from any input.
REQ-017 Disarm SHALL have top priority: Disarm=1 at an edge in any state gives DISARMED and Count=0 next cycle, and clears Tripped.
REQ-018 DISARMED: Arm=1 (with Disarm=0) -> ARMED; A SHALL be ignored.
REQ-019 ARMED: A=1 -> ENTRY with Count loaded to ENTRY_DELAY-1; otherwise stay in ARMED.
REQ-020 ENTRY: Count!=0 -> decrement; Count==0 -> SIREN with Count loaded to SIREN_TIME-1; A SHALL be ignored.
REQ-021 SIREN: Count!=0 -> decrement; Count==0 -> ARMED with Count=0, regardless of A.
REQ-022 Returning to ARMED from SIREN SHALL allow a new trip, with A sampled from the first ARMED cycle onward.
REQ-023 Timing: A=1 sampled at edge k in ARMED gives Pending=1 from k+1 for exactly ENTRY_DELAY cycles, then Siren=1 from k+1+ENTRY_DELAY for exactly SIREN_TIME cycles.
REQ-024 Tripped SHALL be set on the edge that enters SIREN, and cleared only by Disarm or Reset.
REQ-025 Arm in any state other than DISARMED SHALL be ignored; Arm=Disarm=1 SHALL resolve to Disarm.
REQ-026 Count SHALL never wrap: decrement occurs only when Count!=0.
REQ-027 Parameters at 1 SHALL give a single-cycle ENTRY or SIREN, with Count=0 throughout.

Reset
REQ-028 Reset=1 SHALL force, asynchronously and without waiting for Clk: State=DISARMED, Count=0, Siren=0, Armed=0, Pending=0, Tripped=0.
REQ-029 Reset asserted mid-ENTRY or mid-SIREN SHALL abort immediately; after release the block stays in DISARMED until Arm.
REQ-030 Outputs SHALL hold their reset values during the first edge after release unless Arm=1 is sampled at that edge.

Verification (defaults 8/16/8)
REQ-031 Reset, Arm=1 one cycle, A=1 one cycle -> Pending high 8 cycles (Count 7..0), then Siren high 16 cycles (Count 15..0), then State=01, Tripped=1.
REQ-032 In DISARMED, A=1 for 50 cycles -> State stays 00, Siren=0, Tripped=0.
REQ-033 Trip, then Disarm=1 at the 3rd ENTRY cycle -> State=00, Pending=0, Count=0 next cycle, and Siren never asserts.
REQ-034 Disarm at the 5th SIREN cycle -> Siren=0, Tripped=0 next cycle; Arm and Disarm high together -> State=00.
REQ-035 Reset pulsed asynchronously between edges mid-SIREN -> Siren falls before the next Clk edge; all outputs at reset values.
REQ-036 After a trip completes with A held at 1 -> one ARMED cycle, then ENTRY again (re-trigger); run the same check with ENTRY_DELAY=SIREN_TIME=1.

Source files
------------

// File: rtl/alarm_siren_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alarm_siren_ctrl
// Description : Alarm panel sequencer. After Arm, an alarm condition (A) opens
//               an entry window of ENTRY_DELAY cycles. The siren then sounds
//               for SIREN_TIME cycles and the panel re-arms itself. Disarm
//               aborts any state and clears the Tripped flag.
// Ports       : Clk     - system clock, rising edge
//               Reset   - asynchronous active-high reset
//               A       - alarm condition (level, synchronous to Clk)
//               Arm     - arm request (level)
//               Disarm  - disarm request (level, overrides everything)
//               Siren   - high in SIREN
//               Armed   - high in ARMED, ENTRY and SIREN
//               Pending - high in ENTRY
//               Tripped - set on entry to SIREN, cleared by Disarm/Reset
//               State   - current state (00 DISARMED, 01 ARMED, 10 ENTRY,
//                         11 SIREN)
//               Count   - remaining cycles of ENTRY/SIREN, 0 otherwise
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_siren_ctrl #(
    parameter int unsigned ENTRY_DELAY = 8,
    parameter int unsigned SIREN_TIME  = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             A,
    input  logic             Arm,
    input  logic             Disarm,
    output logic             Siren,
    output logic             Armed,
    output logic             Pending,
    output logic             Tripped,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] Count
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_ENTRY    = 2'b10,
        ST_SIREN    = 2'b11
    } state_t;

    // Counter load values: the timed state lasts (load + 1) cycles because the
    // exit happens on the cycle where the counter already reads zero.
    localparam logic [CNT_W-1:0] c_entry_load = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] c_siren_load = CNT_W'(SIREN_TIME - 1);
    localparam logic [CNT_W-1:0] c_cnt_zero   = '0;
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_tripped;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_tripped_nxt;

    // State, counter and trip flag registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_DISARMED;
            r_count   <= c_cnt_zero;
            r_tripped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_tripped <= w_tripped_nxt;
        end
    end

    // Next-state logic. Disarm is checked first so it wins over Arm and over
    // any timed state; Arm is only honoured from DISARMED.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_tripped_nxt = r_tripped;

        if (Disarm) begin
            w_state_nxt   = ST_DISARMED;
            w_count_nxt   = c_cnt_zero;
            w_tripped_nxt = 1'b0;
        end else begin
            unique case (r_state)
                ST_DISARMED: begin
                    w_count_nxt = c_cnt_zero;
                    if (Arm) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    w_count_nxt = c_cnt_zero;
                    if (A) begin
                        w_state_nxt = ST_ENTRY;
                        w_count_nxt = c_entry_load;
                    end
                end
                ST_ENTRY: begin
                    if (r_count != c_cnt_zero) begin
                        w_count_nxt = r_count - c_cnt_one;
                    end else begin
                        w_state_nxt   = ST_SIREN;
                        w_count_nxt   = c_siren_load;
                        w_tripped_nxt = 1'b1;
                    end
                end
                ST_SIREN: begin
                    if (r_count != c_cnt_zero) begin
                        w_count_nxt = r_count - c_cnt_one;
                    end else begin
                        // Back to ARMED so A can re-trip from the next cycle.
                        w_state_nxt = ST_ARMED;
                        w_count_nxt = c_cnt_zero;
                    end
                end
                default: begin
                    w_state_nxt = ST_DISARMED;
                    w_count_nxt = c_cnt_zero;
                end
            endcase
        end
    end

    // Moore outputs decoded from registers only
    assign Siren   = (r_state == ST_SIREN);
    assign Pending = (r_state == ST_ENTRY);
    assign Armed   = (r_state != ST_DISARMED);
    assign Tripped = r_tripped;
    assign State   = r_state;
    assign Count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alarm_siren_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_siren_ctrl
// Description : Directed self-checking bench for alarm_siren_ctrl. One
//               instance uses the 8/16/8 defaults, a second uses 1/1/8 for
//               the single-cycle timing case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_siren_ctrl;

    logic       Clk;
    logic       Reset;
    logic       A, Arm, Disarm;
    logic       Siren, Armed, Pending, Tripped;
    logic [1:0] State;
    logic [7:0] Count;

    logic       A1, Arm1, Disarm1;
    logic       Siren1, Armed1, Pending1, Tripped1;
    logic [1:0] State1;
    logic [7:0] Count1;

    int checks;
    int errors;

    alarm_siren_ctrl #(
        .ENTRY_DELAY (8),
        .SIREN_TIME  (16),
        .CNT_W       (8)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .A       (A),
        .Arm     (Arm),
        .Disarm  (Disarm),
        .Siren   (Siren),
        .Armed   (Armed),
        .Pending (Pending),
        .Tripped (Tripped),
        .State   (State),
        .Count   (Count)
    );

    alarm_siren_ctrl #(
        .ENTRY_DELAY (1),
        .SIREN_TIME  (1),
        .CNT_W       (8)
    ) dut1 (
        .Clk     (Clk),
        .Reset   (Reset),
        .A       (A1),
        .Arm     (Arm1),
        .Disarm  (Disarm1),
        .Siren   (Siren1),
        .Armed   (Armed1),
        .Pending (Pending1),
        .Tripped (Tripped1),
        .State   (State1),
        .Count   (Count1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Packed view of all default-instance outputs: {Siren,Armed,Pending,Tripped,State,Count}
    function automatic logic [13:0] snap();
        return {Siren, Armed, Pending, Tripped, State, Count};
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (snap() !== 14'h0) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", snap(), 14'h0);
        end
        tick();
        tick();
        Reset = 1'b0;
        tick();
        checks++;
        if (snap() !== 14'h0) begin
            errors++;
            $display("FAIL reset_first_edge: got %h expected %h", snap(), 14'h0);
        end
    endtask

    task automatic test_full_trip();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        checks++;
        if (snap() !== {4'b0100, 2'b01, 8'd0}) begin
            errors++;
            $display("FAIL arm: got %h expected %h", snap(), {4'b0100, 2'b01, 8'd0});
        end
        A = 1'b1;
        tick();
        A = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (snap() !== {4'b0110, 2'b10, 8'(7 - i)}) begin
                errors++;
                $display("FAIL entry_cycle_%0d: got %h expected %h", i, snap(), {4'b0110, 2'b10, 8'(7 - i)});
            end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (snap() !== {4'b1101, 2'b11, 8'(15 - i)}) begin
                errors++;
                $display("FAIL siren_cycle_%0d: got %h expected %h", i, snap(), {4'b1101, 2'b11, 8'(15 - i)});
            end
            tick();
        end
        checks++;
        if (snap() !== {4'b0101, 2'b01, 8'd0}) begin
            errors++;
            $display("FAIL trip_done: got %h expected %h", snap(), {4'b0101, 2'b01, 8'd0});
        end
    endtask

    task automatic test_disarmed_ignores_a();
        Disarm = 1'b1;
        tick();
        Disarm = 1'b0;
        checks++;
        if (snap() !== 14'h0) begin
            errors++;
            $display("FAIL disarm_clears_tripped: got %h expected %h", snap(), 14'h0);
        end
        A = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (snap() !== 14'h0) begin
                errors++;
                $display("FAIL disarmed_a_cycle_%0d: got %h expected %h", i, snap(), 14'h0);
            end
        end
        A = 1'b0;
    endtask

    task automatic test_disarm_entry();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        A = 1'b1;
        tick();                 // ENTRY cycle 1, Count 7
        A = 1'b0;
        Arm = 1'b1;             // Arm must be ignored in ENTRY
        tick();                 // ENTRY cycle 2
        Arm = 1'b0;
        tick();                 // ENTRY cycle 3, Count 5
        checks++;
        if (snap() !== {4'b0110, 2'b10, 8'd5}) begin
            errors++;
            $display("FAIL entry_3rd_cycle: got %h expected %h", snap(), {4'b0110, 2'b10, 8'd5});
        end
        Disarm = 1'b1;
        tick();
        Disarm = 1'b0;
        checks++;
        if (snap() !== 14'h0) begin
            errors++;
            $display("FAIL disarm_in_entry: got %h expected %h", snap(), 14'h0);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if ({Siren, State} !== 3'b000) begin
                errors++;
                $display("FAIL no_siren_after_abort_%0d: got %b expected %b", i, {Siren, State}, 3'b000);
            end
        end
    endtask

    task automatic test_disarm_siren();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        A = 1'b1;
        tick();
        A = 1'b0;
        repeat (8) tick();      // SIREN cycle 1
        repeat (4) tick();      // SIREN cycle 5, Count 11
        checks++;
        if (snap() !== {4'b1101, 2'b11, 8'd11}) begin
            errors++;
            $display("FAIL siren_5th_cycle: got %h expected %h", snap(), {4'b1101, 2'b11, 8'd11});
        end
        Disarm = 1'b1;
        tick();
        Disarm = 1'b0;
        checks++;
        if (snap() !== 14'h0) begin
            errors++;
            $display("FAIL disarm_in_siren: got %h expected %h", snap(), 14'h0);
        end
        Arm = 1'b1;
        tick();
        checks++;
        if (State !== 2'b01) begin
            errors++;
            $display("FAIL rearm: got %b expected %b", State, 2'b01);
        end
        Disarm = 1'b1;
        tick();
        checks++;
        if (State !== 2'b00) begin
            errors++;
            $display("FAIL arm_and_disarm_from_armed: got %b expected %b", State, 2'b00);
        end
        tick();
        checks++;
        if (State !== 2'b00) begin
            errors++;
            $display("FAIL arm_and_disarm_from_disarmed: got %b expected %b", State, 2'b00);
        end
        Arm = 1'b0;
        Disarm = 1'b0;
    endtask

    task automatic test_async_reset();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        A = 1'b1;
        tick();
        A = 1'b0;
        repeat (10) tick();     // SIREN cycle 3
        checks++;
        if (Siren !== 1'b1) begin
            errors++;
            $display("FAIL siren_before_reset: got %b expected %b", Siren, 1'b1);
        end
        #2;
        Reset = 1'b1;
        #1;                     // well before the next rising edge
        checks++;
        if (snap() !== 14'h0) begin
            errors++;
            $display("FAIL async_reset_mid_siren: got %h expected %h", snap(), 14'h0);
        end
        #2;
        Reset = 1'b0;
        tick();
        tick();
        checks++;
        if (snap() !== 14'h0) begin
            errors++;
            $display("FAIL stay_disarmed_after_reset: got %h expected %h", snap(), 14'h0);
        end
    endtask

    task automatic test_retrigger();
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        A = 1'b1;
        tick();
        repeat (24) tick();     // 8 ENTRY + 16 SIREN cycles
        checks++;
        if (snap() !== {4'b0101, 2'b01, 8'd0}) begin
            errors++;
            $display("FAIL retrigger_armed_gap: got %h expected %h", snap(), {4'b0101, 2'b01, 8'd0});
        end
        tick();
        checks++;
        if (snap() !== {4'b0111, 2'b10, 8'd7}) begin
            errors++;
            $display("FAIL retrigger_entry: got %h expected %h", snap(), {4'b0111, 2'b10, 8'd7});
        end
        A = 1'b0;
        Disarm = 1'b1;
        tick();
        Disarm = 1'b0;
    endtask

    task automatic test_retrigger_min();
        Arm1 = 1'b1;
        tick();
        Arm1 = 1'b0;
        A1 = 1'b1;
        tick();
        checks++;
        if ({Siren1, Armed1, Pending1, Tripped1, State1, Count1} !== {4'b0110, 2'b10, 8'd0}) begin
            errors++;
            $display("FAIL min_entry: got %h expected %h", {Siren1, Armed1, Pending1, Tripped1, State1, Count1}, {4'b0110, 2'b10, 8'd0});
        end
        tick();
        checks++;
        if ({Siren1, Armed1, Pending1, Tripped1, State1, Count1} !== {4'b1101, 2'b11, 8'd0}) begin
            errors++;
            $display("FAIL min_siren: got %h expected %h", {Siren1, Armed1, Pending1, Tripped1, State1, Count1}, {4'b1101, 2'b11, 8'd0});
        end
        tick();
        checks++;
        if ({Siren1, Armed1, Pending1, Tripped1, State1, Count1} !== {4'b0101, 2'b01, 8'd0}) begin
            errors++;
            $display("FAIL min_armed_gap: got %h expected %h", {Siren1, Armed1, Pending1, Tripped1, State1, Count1}, {4'b0101, 2'b01, 8'd0});
        end
        tick();
        checks++;
        if ({Siren1, Armed1, Pending1, Tripped1, State1, Count1} !== {4'b0111, 2'b10, 8'd0}) begin
            errors++;
            $display("FAIL min_retrigger_entry: got %h expected %h", {Siren1, Armed1, Pending1, Tripped1, State1, Count1}, {4'b0111, 2'b10, 8'd0});
        end
        A1 = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        Reset   = 1'b1;
        A       = 1'b0;
        Arm     = 1'b0;
        Disarm  = 1'b0;
        A1      = 1'b0;
        Arm1    = 1'b0;
        Disarm1 = 1'b0;

        test_reset();
        test_full_trip();
        test_disarmed_ignores_a();
        test_disarm_entry();
        test_disarm_siren();
        test_async_reset();
        test_retrigger();
        test_retrigger_min();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case the clock or a task stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
